phaser_out_tap_ctrl: RTL and testbench

Sequencer that sits directly upstream of the PHASER_OUT_PHY delay-adjust inputs. It takes a target coarse/fine tap setting over a valid/ready handshake and walks the phaser there one tap at a time, driving COARSEENABLE/COARSEINC and then FINEENABLE/FINEINC with a fixed inter-pulse gap. It tracks the current tap counts and aborts on COARSEOVERFLOW/FINEOVERFLOW. Calibration logic uses it instead of toggling phaser inc/dec pins directly.

---
 rtl/phaser_out_tap_ctrl_if.sv | 37 +++
 rtl/phaser_out_tap_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_phaser_out_tap_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phaser_out_tap_ctrl_if.sv
// ---------------------------------------------------------------------------
// phaser_out_tap_ctrl_if
//
// Request channel into phaser_out_tap_ctrl: a target coarse/fine tap pair.
//
// Handshake: a request transfers on a rising SYSCLK edge where REQVALID and
// REQREADY are both high. REQCOARSE/REQFINE are sampled only on that edge.
// REQREADY is high only while the sequencer is idle. REQVALID may be held
// high across a busy period; the held request then transfers on the first
// edge with REQREADY high. Nothing is latched while REQREADY is low.
//
// Signals:
//   REQVALID   requester -> sequencer  target request valid
//   REQREADY   sequencer -> requester  sequencer can accept a request
//   REQCOARSE  requester -> sequencer  target coarse tap (0..63)
//   REQFINE    requester -> sequencer  target fine tap (0..63)
// ---------------------------------------------------------------------------
interface phaser_out_tap_ctrl_if;
  logic       REQVALID;
  logic       REQREADY;
  logic [5:0] REQCOARSE;
  logic [5:0] REQFINE;

  modport master (
    output REQVALID,
    output REQCOARSE,
    output REQFINE,
    input  REQREADY
  );

  modport slave (
    input  REQVALID,
    input  REQCOARSE,
    input  REQFINE,
    output REQREADY
  );
endinterface

// File: rtl/phaser_out_tap_ctrl.sv
// ---------------------------------------------------------------------------
// phaser_out_tap_ctrl
//
// Walks a PHASER_OUT_PHY from its current coarse/fine tap setting to a
// requested one, one tap per pulse. All coarse steps are issued before the
// first fine step, and consecutive enable pulses are PULSE_GAP cycles apart.
// The current tap counts are tracked locally; an overflow flag from the
// phaser aborts the request, sets the sticky ERROR flag and ends with DONE.
//
// Parameters:
//   COARSE_DELAY_INIT  coarse tap count after reset (phaser COARSE_DELAY)
//   FINE_DELAY_INIT    fine tap count after reset (phaser FINE_DELAY)
//   PULSE_GAP          cycles from one enable pulse to the next (2..255)
//
// Ports:
//   SYSCLK          clock, rising edge
//   RST             synchronous active-high reset
//   req             request channel (slave side, see phaser_out_tap_ctrl_if)
//   COARSEENABLE    one-cycle coarse step pulse
//   COARSEINC       coarse direction (1 = increment), valid with COARSEENABLE
//   FINEENABLE      one-cycle fine step pulse
//   FINEINC         fine direction (1 = increment), valid with FINEENABLE
//   COARSEOVERFLOW  phaser coarse overflow
//   FINEOVERFLOW    phaser fine overflow
//   CURCOARSE       current coarse tap count
//   CURFINE         current fine tap count
//   BUSY            high whenever the sequencer is not idle
//   DONE            one-cycle completion pulse (also after an abort)
//   ERROR           last request aborted on overflow; sticky until next accept
//   dbg_state       current FSM state encoding (observation only)
//
// Every output is a flop; nothing combinational reaches an output.
// ---------------------------------------------------------------------------
module phaser_out_tap_ctrl #(
  parameter int COARSE_DELAY_INIT = 0,
  parameter int FINE_DELAY_INIT   = 0,
  parameter int PULSE_GAP         = 8
) (
  input  logic                  SYSCLK,
  input  logic                  RST,
  phaser_out_tap_ctrl_if.slave  req,
  output logic                  COARSEENABLE,
  output logic                  COARSEINC,
  output logic                  FINEENABLE,
  output logic                  FINEINC,
  input  logic                  COARSEOVERFLOW,
  input  logic                  FINEOVERFLOW,
  output logic [5:0]            CURCOARSE,
  output logic [5:0]            CURFINE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [2:0]            dbg_state
);

  // Elaboration-time parameter guard: reports the problem and stops.
  if (PULSE_GAP < 2 || PULSE_GAP > 255) begin : g_bad_gap
    $fatal(1, "phaser_out_tap_ctrl: PULSE_GAP=%0d outside 2..255", PULSE_GAP);
  end
  if (COARSE_DELAY_INIT < 0 || COARSE_DELAY_INIT > 63 ||
      FINE_DELAY_INIT < 0 || FINE_DELAY_INIT > 63) begin : g_bad_init
    $fatal(1, "phaser_out_tap_ctrl: tap init values must be within 0..63");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C_STEP = 3'd1,
    C_WAIT = 3'd2,
    F_STEP = 3'd3,
    F_WAIT = 3'd4,
    FIN    = 3'd5
  } state_t;

  localparam logic [5:0] COARSE_RST = 6'(COARSE_DELAY_INIT);
  localparam logic [5:0] FINE_RST   = 6'(FINE_DELAY_INIT);
  // A step cycle plus PULSE_GAP-1 wait cycles make one pulse period; the
  // wait counter counts down from PULSE_GAP-2 to 0 inclusive.
  localparam logic [7:0] GAP_LOAD   = 8'(PULSE_GAP - 2);

  state_t     state;
  logic [5:0] tgt_coarse;
  logic [5:0] tgt_fine;
  logic [7:0] gap_cnt;
  logic       req_ready;

  // Target being compared against: in IDLE the request on the bus (it is
  // latched on the same edge), otherwise the latched target.
  logic [5:0] sel_coarse;
  logic [5:0] sel_fine;
  state_t     dispatch;
  logic       launch_c;
  logic       launch_f;
  logic       launch_fin;
  logic       coarse_up;
  logic       fine_up;

  assign req.REQREADY = req_ready;
  assign dbg_state    = state;

  // Next step decision shared by request acceptance and wait expiry:
  // coarse first, then fine, otherwise finish. The unsigned compare picks
  // the direction, so the counters can never wrap past 0 or 63.
  always_comb begin
    sel_coarse = tgt_coarse;
    sel_fine   = tgt_fine;
    if (state == IDLE) begin
      sel_coarse = req.REQCOARSE;
      sel_fine   = req.REQFINE;
    end
    coarse_up = (sel_coarse > CURCOARSE);
    fine_up   = (sel_fine > CURFINE);
    if (sel_coarse != CURCOARSE) begin
      dispatch = C_STEP;
    end else if (sel_fine != CURFINE) begin
      dispatch = F_STEP;
    end else begin
      dispatch = FIN;
    end
    launch_c   = (dispatch == C_STEP);
    launch_f   = (dispatch == F_STEP);
    launch_fin = (dispatch == FIN);
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state        <= IDLE;
      tgt_coarse   <= COARSE_RST;
      tgt_fine     <= FINE_RST;
      gap_cnt      <= 8'd0;
      req_ready    <= 1'b1;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
      COARSEENABLE <= 1'b0;
      COARSEINC    <= 1'b0;
      FINEENABLE   <= 1'b0;
      FINEINC      <= 1'b0;
      CURCOARSE    <= COARSE_RST;
      CURFINE      <= FINE_RST;
    end else begin
      // Pulses last exactly one cycle unless a branch below re-arms them.
      COARSEENABLE <= 1'b0;
      COARSEINC    <= 1'b0;
      FINEENABLE   <= 1'b0;
      FINEINC      <= 1'b0;
      DONE         <= 1'b0;

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          BUSY      <= 1'b0;
          if (req.REQVALID) begin
            tgt_coarse   <= req.REQCOARSE;
            tgt_fine     <= req.REQFINE;
            ERROR        <= 1'b0;
            req_ready    <= 1'b0;
            BUSY         <= 1'b1;
            state        <= dispatch;
            COARSEENABLE <= launch_c;
            COARSEINC    <= launch_c && coarse_up;
            FINEENABLE   <= launch_f;
            FINEINC      <= launch_f && fine_up;
            DONE         <= launch_fin;
          end
        end

        C_STEP: begin
          // The pulse is already on the wire, so the count moves even if
          // this cycle also reports an overflow.
          CURCOARSE <= COARSEINC ? CURCOARSE + 6'd1 : CURCOARSE - 6'd1;
          gap_cnt   <= GAP_LOAD;
          if (COARSEOVERFLOW) begin
            ERROR <= 1'b1;
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            state <= C_WAIT;
          end
        end

        C_WAIT: begin
          if (COARSEOVERFLOW) begin
            ERROR <= 1'b1;
            DONE  <= 1'b1;
            state <= FIN;
          end else if (gap_cnt == 8'd0) begin
            state        <= dispatch;
            COARSEENABLE <= launch_c;
            COARSEINC    <= launch_c && coarse_up;
            FINEENABLE   <= launch_f;
            FINEINC      <= launch_f && fine_up;
            DONE         <= launch_fin;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        F_STEP: begin
          CURFINE <= FINEINC ? CURFINE + 6'd1 : CURFINE - 6'd1;
          gap_cnt <= GAP_LOAD;
          if (FINEOVERFLOW) begin
            ERROR <= 1'b1;
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            state <= F_WAIT;
          end
        end

        F_WAIT: begin
          if (FINEOVERFLOW) begin
            ERROR <= 1'b1;
            DONE  <= 1'b1;
            state <= FIN;
          end else if (gap_cnt == 8'd0) begin
            state        <= dispatch;
            COARSEENABLE <= launch_c;
            COARSEINC    <= launch_c && coarse_up;
            FINEENABLE   <= launch_f;
            FINEINC      <= launch_f && fine_up;
            DONE         <= launch_fin;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        FIN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          BUSY      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phaser_out_tap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phaser_out_tap_ctrl
//
// Bench for phaser_out_tap_ctrl with PULSE_GAP=8 and both tap inits 0.
// Expected behaviour per request comes from a timeline model: with c coarse
// and f fine steps, pulse j sits at cycle 1+j*PG after acceptance (coarse for
// j<c), DONE one cycle after the last step period, and an overflow inside the
// matching phase cuts the timeline at that cycle.
// ---------------------------------------------------------------------------
module tb_phaser_out_tap_ctrl;
  localparam int PG = 8;

  // ---------------- clock / reset ----------------
  logic       SYSCLK = 1'b0;
  logic       RST;
  logic       COARSEENABLE, COARSEINC, FINEENABLE, FINEINC;
  logic       COARSEOVERFLOW, FINEOVERFLOW;
  logic [5:0] CURCOARSE, CURFINE;
  logic       BUSY, DONE, ERROR;
  logic [2:0] dbg_state;

  phaser_out_tap_ctrl_if req_if ();

  phaser_out_tap_ctrl #(
    .COARSE_DELAY_INIT(0),
    .FINE_DELAY_INIT  (0),
    .PULSE_GAP        (PG)
  ) dut (
    .SYSCLK        (SYSCLK),
    .RST           (RST),
    .req           (req_if),
    .COARSEENABLE  (COARSEENABLE),
    .COARSEINC     (COARSEINC),
    .FINEENABLE    (FINEENABLE),
    .FINEINC       (FINEINC),
    .COARSEOVERFLOW(COARSEOVERFLOW),
    .FINEOVERFLOW  (FINEOVERFLOW),
    .CURCOARSE     (CURCOARSE),
    .CURFINE       (CURFINE),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERROR         (ERROR),
    .dbg_state     (dbg_state)
  );

  always #5 SYSCLK = ~SYSCLK;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int m_cc     = 0;   // model coarse tap
  int m_cf     = 0;   // model fine tap
  // Expected pulses: [15] fine, [14] increment, [13:0] cycle after acceptance
  logic [15:0] exp_q[$];

  typedef struct {
    int   tc;
    int   tf;
    int   ovfc;
    int   ovff;
    int   exp_done;
    int   exp_c;
    int   exp_f;
    logic exp_err;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] snap();
    return {12'd0, req_if.REQREADY, BUSY, DONE, ERROR, COARSEENABLE, COARSEINC,
            FINEENABLE, FINEINC, CURCOARSE, CURFINE};
  endfunction

  function automatic logic [31:0] mk(input bit rdy, input bit bsy, input bit dn,
                                     input bit er, input bit ce, input bit ci,
                                     input bit fe, input bit fi,
                                     input int cc, input int cf);
    return {12'd0, rdy, bsy, dn, er, ce, ci, fe, fi, 6'(cc), 6'(cf)};
  endfunction

  // ---------------- driver + model ----------------
  task automatic run_req(input int tc, input int tf, input int ovfc_k,
                         input int ovff_k, input int rst_k, output int done_seen);
    int c, f, abort_k, end_k, done_k, npul, w;
    int nn, nb, ncb, nfb, ec, ef;
    bit up_c, up_f, pe;
    logic [15:0] rec;
    done_seen = 0;
    up_c = (tc > m_cc);
    up_f = (tf > m_cf);
    c = up_c ? tc - m_cc : m_cc - tc;
    f = up_f ? tf - m_cf : m_cf - tf;
    abort_k = 0;
    if (ovfc_k >= 1 && ovfc_k <= c * PG) abort_k = ovfc_k;
    else if (ovff_k > c * PG && ovff_k <= (c + f) * PG) abort_k = ovff_k;
    end_k  = (abort_k != 0) ? abort_k : (c + f) * PG;
    done_k = end_k + 1;
    npul   = (end_k == 0) ? 0 : (end_k - 1) / PG + 1;
    exp_q.delete();
    for (int j = 0; j < npul; j++) begin
      exp_q.push_back({(j >= c), (j >= c) ? up_f : up_c, 14'(1 + j * PG)});
    end

    @(negedge SYSCLK);
    w = 0;
    while (!req_if.REQREADY && w < 50) begin
      @(negedge SYSCLK);
      w++;
    end
    if (!req_if.REQREADY) begin
      check("ready_wait", 32'(req_if.REQREADY), 32'd1);
      return;
    end
    req_if.REQVALID  = 1'b1;
    req_if.REQCOARSE = 6'(tc);
    req_if.REQFINE   = 6'(tf);
    @(posedge SYSCLK);

    for (int k = 1; k <= done_k + 1; k++) begin
      @(negedge SYSCLK);
      if (k == 1) req_if.REQVALID = 1'b0;
      pe = (exp_q.size() > 0) && (exp_q[0][13:0] == 14'(k));
      rec = 16'd0;
      if (pe) rec = exp_q.pop_front();
      nn  = (end_k < k - 1) ? end_k : k - 1;
      nb  = (nn == 0) ? 0 : (nn - 1) / PG + 1;
      ncb = (nb < c) ? nb : c;
      nfb = nb - ncb;
      ec  = up_c ? m_cc + ncb : m_cc - ncb;
      ef  = up_f ? m_cf + nfb : m_cf - nfb;
      check("cycle", snap(),
            mk(k > done_k, k <= done_k, k == done_k, (abort_k != 0) && (k > abort_k),
               pe && !rec[15], pe && !rec[15] && rec[14],
               pe && rec[15], pe && rec[15] && rec[14], ec, ef));
      if (DONE) done_seen = k;
      if (k == rst_k) begin
        COARSEOVERFLOW = 1'b0;
        FINEOVERFLOW   = 1'b0;
        RST = 1'b1;
        @(negedge SYSCLK);
        RST = 1'b0;
        check("after_rst", snap(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        m_cc = 0;
        m_cf = 0;
        return;
      end
      COARSEOVERFLOW = (k == ovfc_k);
      FINEOVERFLOW   = (k == ovff_k);
    end
    COARSEOVERFLOW = 1'b0;
    FINEOVERFLOW   = 1'b0;
    check("pulse_q_empty", 32'(exp_q.size()), 32'd0);
    ncb  = (npul < c) ? npul : c;
    nfb  = npul - ncb;
    m_cc = up_c ? m_cc + ncb : m_cc - ncb;
    m_cf = up_f ? m_cf + nfb : m_cf - nfb;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ds, n_p, n_bad, d_at, r_at, w;
    RST = 1'b1;
    req_if.REQVALID  = 1'b0;
    req_if.REQCOARSE = 6'd0;
    req_if.REQFINE   = 6'd0;
    COARSEOVERFLOW   = 1'b0;
    FINEOVERFLOW     = 1'b0;

    tbl[0]  = '{3,  0,  0, 0,  25,   3,  0,  1'b0};
    tbl[1]  = '{1,  2,  0, 0,  33,   1,  2,  1'b0};
    tbl[2]  = '{1,  2,  0, 0,  1,    1,  2,  1'b0};
    tbl[3]  = '{1,  0,  0, 0,  17,   1,  0,  1'b0};
    tbl[4]  = '{1,  10, 0, 28, 29,   1,  4,  1'b1};
    tbl[5]  = '{1,  4,  0, 0,  1,    1,  4,  1'b0};
    tbl[6]  = '{63, 63, 0, 0,  969,  63, 63, 1'b0};
    tbl[7]  = '{0,  0,  0, 0,  1009, 0,  0,  1'b0};
    tbl[8]  = '{5,  5,  5, 0,  6,    1,  0,  1'b1};
    tbl[9]  = '{3,  0,  1, 0,  2,    2,  0,  1'b1};
    tbl[10] = '{4,  1,  0, 3,  25,   4,  1,  1'b0};

    repeat (3) @(posedge SYSCLK);
    @(negedge SYSCLK);
    RST = 1'b0;
    check("reset_state", snap(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_req(tbl[i].tc, tbl[i].tf, tbl[i].ovfc, tbl[i].ovff, 0, ds);
      check("tbl_done_cycle", 32'(ds), 32'(tbl[i].exp_done));
      check("tbl_taps", {20'd0, CURCOARSE, CURFINE}, {20'd0, 6'(tbl[i].exp_c), 6'(tbl[i].exp_f)});
      check("tbl_error", 32'(ERROR), 32'(tbl[i].exp_err));
    end

    // Reset during the 2nd C_WAIT of a 5-step request, then a fresh request
    run_req(9, 1, 0, 0, 12, ds);
    check("rst_no_done", 32'(ds), 32'd0);
    run_req(2, 1, 0, 0, 0, ds);
    check("post_rst_done", 32'(ds), 32'd25);
    check("post_rst_taps", {20'd0, CURCOARSE, CURFINE}, {20'd0, 6'd2, 6'd1});

    // REQVALID held through BUSY with the coarse target changed mid-flight
    @(negedge SYSCLK);
    req_if.REQVALID  = 1'b1;
    req_if.REQCOARSE = 6'd4;
    req_if.REQFINE   = 6'd1;
    @(posedge SYSCLK);
    n_p = 0; n_bad = 0; d_at = 0; r_at = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge SYSCLK);
      if (k == 1) req_if.REQCOARSE = 6'd0;
      if (k <= 17 && COARSEENABLE && COARSEINC) n_p++;
      if (k <= 17 && (FINEENABLE || (COARSEENABLE && !COARSEINC))) n_bad++;
      if (DONE && d_at == 0) d_at = k;
      if (req_if.REQREADY && r_at == 0) r_at = k;
      if (k == 19) check("held_second_pulse", {29'd0, COARSEENABLE, COARSEINC, req_if.REQREADY}, 32'b100);
    end
    req_if.REQVALID = 1'b0;
    check("held_up_pulses", 32'(n_p), 32'd2);
    check("held_stray_pulses", 32'(n_bad), 32'd0);
    check("held_done_cycle", 32'(d_at), 32'd17);
    check("held_ready_cycle", 32'(r_at), 32'd18);
    w = 0;
    while (!DONE && w < 60) begin
      @(negedge SYSCLK);
      w++;
    end
    check("held_second_done", 32'(DONE), 32'd1);
    check("held_taps", {20'd0, CURCOARSE, CURFINE}, {20'd0, 6'd0, 6'd1});
    m_cc = 0;
    m_cf = 1;

    // Randomized requests against the timeline model
    for (int i = 0; i < 20; i++) begin
      int tc, tf, sel, oc, of;
      tc  = int'($urandom_range(0, 63));
      tf  = int'($urandom_range(0, 63));
      sel = int'($urandom_range(0, 3));
      oc  = (sel == 0) ? int'($urandom_range(1, 600)) : 0;
      of  = (sel == 1) ? int'($urandom_range(1, 1100)) : 0;
      run_req(tc, tf, oc, of, 0, ds);
      check("rand_taps", {20'd0, CURCOARSE, CURFINE}, {20'd0, 6'(m_cc), 6'(m_cf)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
